// File: rtl/spec_sched_pkg.sv
// Shared definitions for the spectrogram ping-pong bank scheduler.
// Holds the frame/data width defaults, the bank address width derivation,
// the reader state encoding and the bank encoding constants.
package spec_sched_pkg;

   localparam int unsigned FRAME_LEN_DEF = 1024;
   localparam int unsigned DATA_W_DEF    = 16;

   // Address width for a bank of frame_len words; never narrower than one bit.
   function automatic int unsigned addr_w_of(input int unsigned frame_len);
      return (frame_len > 1) ? $clog2(frame_len) : 1;
   endfunction

   localparam int unsigned ADDR_W_DEF = addr_w_of(FRAME_LEN_DEF);

   typedef enum logic {
      R_IDLE = 1'b0,
      R_BUSY = 1'b1
   } rd_state_e;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/spec_bank_scheduler_result_majority3.sv
// result_majority3: 3-deep history of classifier decisions and their majority.
// Ports:
//   clk_25   - system clock
//   RST_N    - asynchronous active-low reset, history clears to 000
//   shift_en - shift bit_in into the history this cycle
//   bit_in   - newest decision
//   stable   - majority of the three most recent decisions
module result_majority3
   import spec_sched_pkg::*;
(
   input  logic clk_25,
   input  logic RST_N,
   input  logic shift_en,
   input  logic bit_in,
   output logic stable
);

   logic [2:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (shift_en) begin
         hist_d = {hist_q[1:0], bit_in};
      end
   end

   always_ff @(posedge clk_25 or negedge RST_N) begin
      if (!RST_N) begin
         hist_q <= 3'b000;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign stable = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/spec_bank_scheduler.sv
// spec_bank_scheduler: ping-pong bank scheduler between the log10 spectrogram
// producer and the classifier. Words are written into bank wb while the
// classifier reads bank rb; a pass starts on the oldest complete frame and a
// bank is only released for writing once its pass reports net_done.
// Ports:
//   clk_25, RST_N         - clock, asynchronous active-low reset
//   in_valid/in_data      - producer word; in_ready accepts it
//   wr_en/wr_bank/
//   wr_addr/wr_data       - registered write port to the external bank RAMs
//   frame_start/frame_bank- start pulse and bank the classifier reads
//   net_done/net_result   - classifier completion and decision
//   result_valid/
//   result_out            - latched decision and its one-cycle strobe
//   result_stable         - majority of the last three decisions
//   stall_cnt             - saturating count of back-pressured cycles
module spec_bank_scheduler
   import spec_sched_pkg::*;
#(
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ADDR_W    = addr_w_of(FRAME_LEN)
) (
   input  logic              clk_25,
   input  logic              RST_N,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_start,
   output logic              frame_bank,
   input  logic              net_done,
   input  logic              net_result,
   output logic              result_valid,
   output logic              result_out,
   output logic              result_stable,
   output logic [15:0]       stall_cnt
);

   logic [1:0]        full_q, full_d;
   logic              wb_q, wb_d;
   logic              rb_q, rb_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   rd_state_e         rstate_q, rstate_d;
   // Registered so it reads 0 while RST_N is low.
   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic              wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_bank_q, frame_bank_d;
   logic              result_valid_q, result_valid_d;
   logic              result_out_q, result_out_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              accept, last_word, done_acc;

   always_comb begin
      full_d         = full_q;
      wb_d           = wb_q;
      rb_d           = rb_q;
      wa_d           = wa_q;
      rstate_d       = rstate_q;
      wr_en_d        = 1'b0;
      wr_bank_d      = wr_bank_q;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      frame_start_d  = 1'b0;
      frame_bank_d   = frame_bank_q;
      result_valid_d = 1'b0;
      result_out_d   = result_out_q;
      stall_cnt_d    = stall_cnt_q;
      done_acc       = 1'b0;

      accept    = in_valid & in_ready_q;
      last_word = (wa_q == ADDR_W'(FRAME_LEN - 1));

      // Writer side.
      if (accept) begin
         wr_en_d   = 1'b1;
         wr_bank_d = wb_q;
         wr_addr_d = wa_q;
         wr_data_d = in_data;
         if (last_word) begin
            full_d[wb_q] = 1'b1;
            wb_d         = (wb_q == BANK_A) ? BANK_B : BANK_A;
            wa_d         = '0;
         end else begin
            wa_d = wa_q + 1'b1;
         end
      end

      // Reader side. The writer can never be completing bank rb while it is
      // full, so clearing full[rb] here never collides with the set above.
      case (rstate_q)
         R_IDLE: begin
            if (full_q[rb_q]) begin
               frame_start_d = 1'b1;
               frame_bank_d  = rb_q;
               rstate_d      = R_BUSY;
            end
         end
         R_BUSY: begin
            if (net_done) begin
               done_acc       = 1'b1;
               full_d[rb_q]   = 1'b0;
               rb_d           = (rb_q == BANK_A) ? BANK_B : BANK_A;
               result_out_d   = net_result;
               result_valid_d = 1'b1;
               rstate_d       = R_IDLE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase

      if (in_valid && !in_ready_q && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end

      in_ready_d = ~full_d[wb_d];
   end

   always_ff @(posedge clk_25 or negedge RST_N) begin
      if (!RST_N) begin
         full_q         <= 2'b00;
         wb_q           <= BANK_A;
         rb_q           <= BANK_A;
         wa_q           <= '0;
         rstate_q       <= R_IDLE;
         in_ready_q     <= 1'b0;
         wr_en_q        <= 1'b0;
         wr_bank_q      <= BANK_A;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         frame_start_q  <= 1'b0;
         frame_bank_q   <= BANK_A;
         result_valid_q <= 1'b0;
         result_out_q   <= 1'b0;
         stall_cnt_q    <= 16'd0;
      end else begin
         full_q         <= full_d;
         wb_q           <= wb_d;
         rb_q           <= rb_d;
         wa_q           <= wa_d;
         rstate_q       <= rstate_d;
         in_ready_q     <= in_ready_d;
         wr_en_q        <= wr_en_d;
         wr_bank_q      <= wr_bank_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         frame_start_q  <= frame_start_d;
         frame_bank_q   <= frame_bank_d;
         result_valid_q <= result_valid_d;
         result_out_q   <= result_out_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   result_majority3 u_majority (
      .clk_25   (clk_25),
      .RST_N    (RST_N),
      .shift_en (done_acc),
      .bit_in   (net_result),
      .stable   (result_stable)
   );

   assign in_ready     = in_ready_q;
   assign wr_en        = wr_en_q;
   assign wr_bank      = wr_bank_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign frame_start  = frame_start_q;
   assign frame_bank   = frame_bank_q;
   assign result_valid = result_valid_q;
   assign result_out   = result_out_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_spec_bank_scheduler.sv
// Scoreboard bench for spec_bank_scheduler: the driver pushes expected writes,
// frame starts and results (with the clock edge they must follow) into queues,
// and a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_spec_bank_scheduler;

   localparam int unsigned FL = 1024;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 10;

   logic          clk_25 = 1'b0;
   logic          RST_N;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          wr_en;
   logic          wr_bank;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          frame_start;
   logic          frame_bank;
   logic          net_done;
   logic          net_result;
   logic          result_valid;
   logic          result_out;
   logic          result_stable;
   logic [15:0]   stall_cnt;

   always #20 clk_25 = ~clk_25;

   spec_bank_scheduler #(
      .FRAME_LEN (FL),
      .DATA_W    (DW),
      .ADDR_W    (AW)
   ) dut (
      .clk_25        (clk_25),
      .RST_N         (RST_N),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .wr_en         (wr_en),
      .wr_bank       (wr_bank),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .frame_start   (frame_start),
      .frame_bank    (frame_bank),
      .net_done      (net_done),
      .net_result    (net_result),
      .result_valid  (result_valid),
      .result_out    (result_out),
      .result_stable (result_stable),
      .stall_cnt     (stall_cnt)
   );

   typedef struct {
      logic          bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            edge_no;
   } wr_exp_t;

   typedef struct {
      logic bank;
      int   edge_no;
   } fs_exp_t;

   typedef struct {
      logic res;
      logic stable;
      int   edge_no;
   } rs_exp_t;

   wr_exp_t wq[$];
   fs_exp_t fq[$];
   rs_exp_t rq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Bench-side writer pointer/address.
   logic          m_wb;
   logic [AW-1:0] m_wa;

   always @(posedge clk_25) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_fs(input logic bank, input int edge_no);
      fs_exp_t f;
      f.bank    = bank;
      f.edge_no = edge_no;
      fq.push_back(f);
   endtask

   task automatic push_rs(input logic res, input logic stable, input int edge_no);
      rs_exp_t r;
      r.res     = res;
      r.stable  = stable;
      r.edge_no = edge_no;
      rq.push_back(r);
   endtask

   // Monitor: outputs registered at edge N are compared at the following negedge.
   wr_exp_t mw;
   fs_exp_t mf;
   rs_exp_t mr;
   always @(negedge clk_25) begin
      if (wr_en === 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
         end else begin
            mw = wq.pop_front();
            chk("wr_bank", 32'(wr_bank), 32'(mw.bank));
            chk("wr_addr", 32'(wr_addr), 32'(mw.addr));
            chk("wr_data", 32'(wr_data), 32'(mw.data));
            chk("wr_cycle", 32'(cyc), 32'(mw.edge_no));
         end
      end
      if (frame_start === 1'b1) begin
         if (fq.size() == 0) begin
            chk("unexpected_frame_start", 32'(frame_bank), 32'hFFFF_FFFF);
         end else begin
            mf = fq.pop_front();
            chk("frame_bank", 32'(frame_bank), 32'(mf.bank));
            chk("frame_start_cycle", 32'(cyc), 32'(mf.edge_no));
         end
      end
      if (result_valid === 1'b1) begin
         if (rq.size() == 0) begin
            chk("unexpected_result_valid", 32'(result_out), 32'hFFFF_FFFF);
         end else begin
            mr = rq.pop_front();
            chk("result_out", 32'(result_out), 32'(mr.res));
            chk("result_stable", 32'(result_stable), 32'(mr.stable));
            chk("result_cycle", 32'(cyc), 32'(mr.edge_no));
         end
      end
   end

   // One clock of stimulus, entered and left at posedge+1. Returns whether the
   // word was accepted and the number of the edge that sampled the inputs.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic nd, input logic nr,
                        output logic hs, output int e);
      wr_exp_t w;
      in_valid   = v;
      in_data    = d;
      net_done   = nd;
      net_result = nr;
      @(negedge clk_25);
      e  = cyc + 1;
      hs = v & in_ready;
      if (hs) begin
         w.bank    = m_wb;
         w.addr    = m_wa;
         w.data    = d;
         w.edge_no = e;
         wq.push_back(w);
         if (m_wa == AW'(FL - 1)) begin
            m_wa = '0;
            m_wb = ~m_wb;
         end else begin
            m_wa = m_wa + 1'b1;
         end
      end
      @(posedge clk_25);
      #1;
      in_valid   = 1'b0;
      net_done   = 1'b0;
      net_result = 1'b0;
   endtask

   // Stream n words base, base+1, ... holding each until accepted.
   task automatic send_words(input int n, input int base, output int last_e);
      logic hs;
      int   e;
      int   guard;
      last_e = 0;
      for (int i = 0; i < n; i++) begin
         hs    = 1'b0;
         guard = 0;
         while (!hs) begin
            drive(1'b1, DW'(base + i), 1'b0, 1'b0, hs, e);
            guard++;
            if (guard > 200) begin
               $display("FAIL send_words: word %0d not accepted within 200 cycles", i);
               $fatal(1);
            end
         end
         last_e = e;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      chk({tag, "_frame_bank"}, 32'(frame_bank), 32'd0);
      chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
      chk({tag, "_result_out"}, 32'(result_out), 32'd0);
      chk({tag, "_result_stable"}, 32'(result_stable), 32'd0);
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic hs;
      int   e;

      RST_N      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      net_done   = 1'b0;
      net_result = 1'b0;
      m_wb       = 1'b0;
      m_wa       = '0;

      repeat (3) @(posedge clk_25);
      #5;
      check_reset_outputs("rst");
      @(negedge clk_25);
      RST_N = 1'b1;
      @(posedge clk_25);
      #1;
      chk("in_ready_after_release", 32'(in_ready), 32'd1);

      // Frame 0 -> bank 0, classifier starts two cycles after the last handshake.
      send_words(FL, 0, e);
      push_fs(1'b0, e + 1);

      // Bank 1 fills while the classifier is busy on bank 0.
      send_words(FL, 16'h4000, e);
      chk("in_ready_both_full", 32'(in_ready), 32'd0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 16'hABCD, 1'b0, 1'b0, hs, e);
         chk("stalled_no_accept", 32'(hs), 32'd0);
         if (i == 9) chk("stall_cnt_10", 32'(stall_cnt), 32'd10);
      end
      chk("stall_cnt_20", 32'(stall_cnt), 32'd20);

      // First pass finishes with result 1: hist 001 -> stable 0; bank 1 starts next.
      drive(1'b1, 16'hABCD, 1'b1, 1'b1, hs, e);
      chk("stalled_on_done_cycle", 32'(hs), 32'd0);
      push_rs(1'b1, 1'b0, e);
      push_fs(1'b1, e + 1);
      chk("in_ready_after_free", 32'(in_ready), 32'd1);
      drive(1'b1, 16'hABCD, 1'b0, 1'b0, hs, e);
      chk("resume_accept", 32'(hs), 32'd1);
      chk("stall_cnt_21", 32'(stall_cnt), 32'd21);

      // Second pass (bank 1) result 0: hist 010 -> stable 0.
      drive(1'b0, 16'h0000, 1'b1, 1'b0, hs, e);
      push_rs(1'b0, 1'b0, e);
      // net_done while idle must be ignored.
      drive(1'b0, 16'h0000, 1'b1, 1'b1, hs, e);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, hs, e);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, hs, e);

      // Finish bank 0 (one word already in), classifier starts on it.
      send_words(FL - 1, 16'h8000, e);
      push_fs(1'b0, e + 1);

      // Bank 1 up to its last word; last word and net_done in the same cycle.
      send_words(FL - 1, 16'hC000, e);
      drive(1'b1, 16'hCFFF, 1'b1, 1'b1, hs, e);
      chk("last_word_with_done_accept", 32'(hs), 32'd1);
      push_rs(1'b1, 1'b1, e);
      push_fs(1'b1, e + 1);
      chk("in_ready_after_swap", 32'(in_ready), 32'd1);

      // Writer resumes on bank 0 and reaches wa=500.
      send_words(500, 16'h1000, e);
      chk("stall_cnt_held", 32'(stall_cnt), 32'd21);
      chk("frame_bank_before_rst", 32'(frame_bank), 32'd1);

      // Asynchronous reset mid-frame.
      #5;
      RST_N = 1'b0;
      #1;
      check_reset_outputs("midrst");
      wq.delete();
      m_wb = 1'b0;
      m_wa = '0;
      @(negedge clk_25);
      RST_N = 1'b1;
      @(posedge clk_25);
      #1;

      // No frame_start until a complete fresh frame has been accepted.
      send_words(FL - 1, 16'h2000, e);
      for (int i = 0; i < 5; i++) drive(1'b0, 16'h0000, 1'b0, 1'b0, hs, e);
      send_words(1, 16'h2FFF, e);
      push_fs(1'b0, e + 1);
      for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b0, 1'b0, hs, e);

      chk("writes_all_seen", 32'(wq.size()), 32'd0);
      chk("frame_starts_all_seen", 32'(fq.size()), 32'd0);
      chk("results_all_seen", 32'(rq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spec_bank_scheduler.md
# spec_bank_scheduler

Ping-pong bank scheduler that sits between the log10 spectrogram producer (SignalPreAnalysis) and the ShuffleNet classifier. It writes incoming log10 words into one of two spectrogram banks while the classifier reads the other, and starts each classifier pass on the oldest complete frame. It also returns classifier completions, so the producer never overwrites a bank under inference. It latches each classification result and produces a 3-frame majority-filtered result for the LEDs.

## Interface
- FRAME_LEN, 1024: log10 words per spectrogram frame (≥2)
- DATA_W, 16: log10 word width
- ADDR_W, $clog2(FRAME_LEN): bank address width
- clk_25  in  1  system clock; all logic on its rising edge
- RST_N  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer word valid (log10_result_Rready)
- in_data  in  DATA_W  producer log10 word
- in_ready  out  1  scheduler accepts word (log10_result_Wready)
- wr_en  out  1  bank RAM write strobe
- wr_bank  out  1  target bank (0=A, 1=B)
- wr_addr  out  ADDR_W  write address within bank
- wr_data  out  DATA_W  write data
- frame_start  out  1  one-cycle pulse: classifier starts on frame_bank
- frame_bank  out  1  bank the classifier reads (select_bramA = ~frame_bank)
- net_done  in  1  one-cycle pulse: classifier finished (Stage==38)
- net_result  in  1  classifier decision, valid with net_done
- result_valid  out  1  one-cycle pulse, a new result was latched
- result_out  out  1  last latched classifier decision
- result_stable  out  1  majority of the last 3 latched decisions
- stall_cnt  out  16  saturating count of cycles with in_valid & !in_ready

## Operation
- Per-bank full[1:0] flags. Writer pointer wb and address wa. Reader pointer rb and reader state R_IDLE/R_BUSY.
- in_ready = !full[wb]. An accepted word is in_valid & in_ready.
- Accepted word: it is written at wa in bank wb, and wa increments. On the word with wa==FRAME_LEN-1: full[wb] is set, wb toggles, and wa returns to 0.
- R_IDLE with full[rb]: frame_start pulses, frame_bank=rb, and the state goes to R_BUSY.
- R_BUSY with net_done: full[rb] clears, rb toggles, result_out<=net_result, result_valid pulses, hist shifts in net_result, and the state goes to R_IDLE.
- net_done in R_IDLE is ignored: no result, no flag change.
- Both banks full: in_ready=0, and stall_cnt counts until the reader frees a bank. Words are never dropped.
- Simultaneous frame completion and net_done on different banks: both take effect in the same cycle.
- If net_done frees bank b in the same cycle the writer is stalled on b, in_ready rises the next cycle.
- result_stable = majority(hist[2:0]); hist resets to 000.
- stall_cnt saturates at 16'hFFFF.

## Timing
- Reset values:
  - in_ready=1 after release (0 while RST_N low).
  - wr_en=0, wr_bank=0, wr_addr=0, wr_data=0.
  - frame_start=0, frame_bank=0.
  - result_valid=0, result_out=0, result_stable=0, stall_cnt=0.
  - Internal state: full=00, wb=rb=0, wa=0, R_IDLE.
- Write outputs are registered. Handshake in cycle T gives wr_en/addr/data/bank in cycle T+1.
- The last word handshake in cycle T sets full in T+1 and gives frame_start in T+2, after the RAM write has landed.
- net_done in cycle T gives result_valid/result_out in T+1 and result_stable in T+1.
- A newly full bank can start a pass earliest in the cycle after the preceding pass's net_done. The next frame_start comes at T+2 relative to that net_done.
- frame_bank is stable from frame_start until the cycle after net_done.
- Asserting RST_N mid-frame discards partial and complete frames immediately. No frame_start may follow until a full FRAME_LEN is rewritten.

## Structure
- Shared package spec_sched_pkg holds:
  - the FRAME_LEN and DATA_W defaults;
  - the ADDR_W derivation;
  - the reader-state enum (R_IDLE, R_BUSY);
  - the bank encoding constants BANK_A=0, BANK_B=1.
- One sub-module: result_majority3, containing the 3-deep history shift register and the majority vote.
- The bank RAMs themselves are outside this block.

## Test plan
- Reset release, then stream FRAME_LEN words of value 0..FRAME_LEN-1:
  - wr_addr 0..FRAME_LEN-1 on bank 0, each one cycle after its handshake;
  - frame_start with frame_bank=0 two cycles after the last handshake.
- Continuous in_valid with net_done withheld:
  - bank 1 fills, then in_ready=0;
  - stall_cnt increments each cycle;
  - net_done with net_result=1 raises in_ready the next cycle, and wr_bank=0.
- Three passes with results 1,0,1: result_out follows 1,0,1 and result_stable=1 after the third result_valid.
- net_done pulsed in R_IDLE: no result_valid, full flags unchanged.
- Last word of bank 1 and net_done for bank 0 in the same cycle: both banks' state updates. frame_start on bank 1 two cycles later, and the writer resumes on bank 0.
- RST_N asserted mid-frame at wa=500: all outputs go to reset values asynchronously. After release, no frame_start until FRAME_LEN new words are accepted.
